inperiph: RTL and testbench

INPERIPH -- requirements
Module: inperiph

---
 rtl/inperiph_if.sv | 11 +
 rtl/inperiph.sv | 116 +++++++++++
 tb/tb_inperiph.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inperiph_if.sv
// Register bus between a host and the input peripheral: one write per clock
// with wren, and rdata decoded combinationally from addr.
interface inperiph_if;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output wren, input rdata);
    modport slave  (input addr, input wdata, input wren, output rdata);
endinterface

// File: rtl/inperiph.sv
// Input peripheral: synchronised slide switches, debounced active-low keys,
// sticky key-press / switch-change flags with W1C clear, and a masked interrupt.
module inperiph #(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    inperiph_if.slave   bus,
    input  logic [17:0] sw,
    input  logic [3:0]  key,
    output logic        irq
);
    localparam logic [15:0] DB_LAST    = 16'(DB_CYCLES - 1);
    localparam logic [7:0]  A_SW       = 8'h00;
    localparam logic [7:0]  A_KEY      = 8'h10;
    localparam logic [7:0]  A_KEY_EVT  = 8'h20;
    localparam logic [7:0]  A_SW_CHG   = 8'h30;
    localparam logic [7:0]  A_IRQ_MASK = 8'h40;

    logic [17:0]      r_sw_s1, r_sw_s2, r_sw_s3;
    logic [3:0]       r_key_s1, r_key_s2;
    logic [3:0][15:0] r_db_cnt;
    logic [3:0]       r_stable;
    logic [3:0]       r_key_evt;
    logic [17:0]      r_sw_chg;
    logic [4:0]       r_irq_mask;
    logic             r_irq;

    logic [3:0]       w_pressed;
    logic [3:0]       w_accept;
    logic [3:0]       w_rise;
    logic [3:0]       w_evt_clr;
    logic [17:0]      w_chg_clr;
    logic [17:0]      w_sw_delta;
    logic             w_mask_we;

    // Keys are active-low on the pins; everything past the synchroniser is 1 = pressed.
    assign w_pressed  = ~r_key_s2;
    assign w_rise     = w_accept & w_pressed;
    assign w_sw_delta = r_sw_s2 ^ r_sw_s3;
    assign w_evt_clr  = (bus.wren && (bus.addr == A_KEY_EVT)) ? bus.wdata[3:0]  : 4'h0;
    assign w_chg_clr  = (bus.wren && (bus.addr == A_SW_CHG))  ? bus.wdata[17:0] : 18'h0;
    assign w_mask_we  = bus.wren && (bus.addr == A_IRQ_MASK);
    assign irq        = r_irq;

    always_comb begin
        w_accept = 4'h0;
        for (int i = 0; i < 4; i++) begin
            w_accept[i] = (w_pressed[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_s1 <= 4'hF;
            r_key_s2 <= 4'hF;
            r_sw_s1  <= 18'h0;
            r_sw_s2  <= 18'h0;
            r_sw_s3  <= 18'h0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_sw_s3  <= r_sw_s2;
        end
    end

    // Any return to the stable level restarts the count, so short glitches never land.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_stable <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_pressed[i] == r_stable[i]) begin
                    r_db_cnt[i] <= 16'h0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= w_pressed[i];
                    r_db_cnt[i] <= 16'h0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 16'h1;
                end
            end
        end
    end

    // Set terms are OR-ed after the clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_evt  <= 4'h0;
            r_sw_chg   <= 18'h0;
            r_irq_mask <= 5'h0;
            r_irq      <= 1'b0;
        end else begin
            r_key_evt <= (r_key_evt & ~w_evt_clr) | w_rise;
            r_sw_chg  <= (r_sw_chg & ~w_chg_clr) | w_sw_delta;
            if (w_mask_we) begin
                r_irq_mask <= bus.wdata[4:0];
            end
            r_irq <= (|(r_key_evt & r_irq_mask[3:0])) | ((|r_sw_chg) & r_irq_mask[4]);
        end
    end

    always_comb begin
        bus.rdata = 32'h0;
        case (bus.addr)
            A_SW:       bus.rdata = {14'h0, r_sw_s2};
            A_KEY:      bus.rdata = {28'h0, r_stable};
            A_KEY_EVT:  bus.rdata = {28'h0, r_key_evt};
            A_SW_CHG:   bus.rdata = {14'h0, r_sw_chg};
            A_IRQ_MASK: bus.rdata = {27'h0, r_irq_mask};
            default:    bus.rdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_inperiph.sv
// Bench for inperiph with DB_CYCLES=4: register table, directed debounce /
// W1C / irq / reset sequences, then random traffic against a history-based model.
module tb_inperiph;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sw;
    logic [3:0]  key;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    inperiph_if bus_if ();

    inperiph #(.DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .sw  (sw),
        .key (key),
        .irq (irq)
    );

    always #5 clk = ~clk;

    // Reference model: raw per-edge pin history. The debouncer at an edge looks
    // at the pin value sampled two edges earlier; a key level flips once the last
    // DB such samples all disagree with the current level.
    logic [3:0]  key_hist[$];
    logic [17:0] sw_hist[$];
    logic [3:0]  m_stable, m_evt;
    logic [17:0] m_chg;
    logic [4:0]  m_mask;
    logic        m_irq;

    task automatic model_step();
        logic [3:0]  nstable, clr_e;
        logic [17:0] clr_c, sw_now, sw_old;
        logic        nirq, all_diff;
        int          n;
        if (rst) begin
            key_hist.delete();
            sw_hist.delete();
            for (int k = 0; k < DB + 3; k++) begin
                key_hist.push_back(4'hF);
                sw_hist.push_back(18'h0);
            end
            m_stable = 0; m_evt = 0; m_chg = 0; m_mask = 0; m_irq = 0;
            return;
        end
        nirq = (|(m_evt & m_mask[3:0])) | ((|m_chg) & m_mask[4]);
        key_hist.push_back(key);
        sw_hist.push_back(sw);
        n = key_hist.size();
        nstable = m_stable;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int d = 0; d < DB; d++)
                if ((~key_hist[n-3-d][i]) == m_stable[i]) all_diff = 1'b0;
            if (all_diff) nstable[i] = ~m_stable[i];
        end
        clr_e = (bus_if.wren && bus_if.addr == 8'h20) ? bus_if.wdata[3:0] : 4'h0;
        clr_c = (bus_if.wren && bus_if.addr == 8'h30) ? bus_if.wdata[17:0] : 18'h0;
        n = sw_hist.size();
        sw_now = sw_hist[n-3];
        sw_old = sw_hist[n-4];
        m_evt = (m_evt & ~clr_e) | (nstable & ~m_stable);
        m_chg = (m_chg & ~clr_c) | (sw_now ^ sw_old);
        if (bus_if.wren && bus_if.addr == 8'h40) m_mask = bus_if.wdata[4:0];
        m_stable = nstable;
        m_irq = nirq;
        while (key_hist.size() > DB + 8) void'(key_hist.pop_front());
        while (sw_hist.size() > DB + 8) void'(sw_hist.pop_front());
    endtask

    function automatic logic [31:0] m_read(logic [7:0] a);
        case (a)
            8'h00:   return {14'h0, sw_hist[sw_hist.size()-2]};
            8'h10:   return {28'h0, m_stable};
            8'h20:   return {28'h0, m_evt};
            8'h30:   return {14'h0, m_chg};
            8'h40:   return {27'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rd_chk(string name, logic [7:0] a, logic [31:0] exp);
        bus_if.addr = a;
        #1;
        check(name, bus_if.rdata, exp);
    endtask

    task automatic wr(logic [7:0] a, logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wren  = 1'b1;
        tick();
        bus_if.wren  = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,        8'h00, 32'h0,  "rst_sw"};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,        8'h10, 32'h0,  "rst_key"};
        vecs[2]  = '{1'b0, 8'h00, 32'h0,        8'h20, 32'h0,  "rst_key_evt"};
        vecs[3]  = '{1'b0, 8'h00, 32'h0,        8'h30, 32'h0,  "rst_sw_chg"};
        vecs[4]  = '{1'b0, 8'h00, 32'h0,        8'h40, 32'h0,  "rst_mask"};
        vecs[5]  = '{1'b1, 8'h40, 32'hFFFFFFFF, 8'h40, 32'h1F, "mask_wr_all"};
        vecs[6]  = '{1'b1, 8'h40, 32'h0000000A, 8'h40, 32'hA,  "mask_wr_a"};
        vecs[7]  = '{1'b1, 8'h00, 32'hFFFFFFFF, 8'h00, 32'h0,  "ro_sw"};
        vecs[8]  = '{1'b1, 8'h10, 32'h0000000F, 8'h10, 32'h0,  "ro_key"};
        vecs[9]  = '{1'b1, 8'h50, 32'h0000FFFF, 8'h40, 32'hA,  "unmapped_wr"};
        vecs[10] = '{1'b1, 8'h44, 32'h0000001F, 8'h40, 32'hA,  "near_mask_wr"};
        vecs[11] = '{1'b0, 8'h00, 32'h0,        8'hFF, 32'h0,  "unmapped_ff"};
        vecs[12] = '{1'b1, 8'h40, 32'h0,        8'h40, 32'h0,  "mask_clr"};

        rst = 1'b1; sw = 18'h0; key = 4'hF;
        bus_if.addr = 8'h0; bus_if.wdata = 32'h0; bus_if.wren = 1'b0;
        @(negedge clk);
        ticks(3);
        rst = 1'b0;
        check("rst_irq", {31'h0, irq}, 32'h0);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].we) wr(vecs[v].waddr, vecs[v].wdata);
            rd_chk(vecs[v].name, vecs[v].raddr, vecs[v].exp);
        end

        // key0 pressed and held
        key[0] = 1'b0;
        ticks(5);
        rd_chk("k0_before_accept", 8'h10, 32'h0);
        tick();
        rd_chk("k0_key", 8'h10, 32'h1);
        rd_chk("k0_evt", 8'h20, 32'h1);
        check("k0_irq_masked", {31'h0, irq}, 32'h0);
        key[0] = 1'b1;
        ticks(8);
        rd_chk("k0_released", 8'h10, 32'h0);
        rd_chk("k0_release_no_evt", 8'h20, 32'h1);
        wr(8'h20, 32'hF);

        // key1 glitch of 3 clocks
        key[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) key[1] = 1'b1;
            tick();
            rd_chk("glitch_key", 8'h10, 32'h0);
            rd_chk("glitch_evt", 8'h20, 32'h0);
        end

        // W1C partial clear, then clear colliding with a new press
        key = 4'b1010;
        ticks(8);
        key = 4'hF;
        ticks(8);
        rd_chk("evt_0x5", 8'h20, 32'h5);
        wr(8'h20, 32'h4);
        rd_chk("w1c_partial", 8'h20, 32'h1);
        wr(8'h20, 32'h1);
        rd_chk("w1c_bit0", 8'h20, 32'h0);
        key[0] = 1'b0;
        ticks(5);
        wr(8'h20, 32'h1);
        rd_chk("set_beats_clr", 8'h20, 32'h1);
        wr(8'h20, 32'hF);
        key[0] = 1'b1;
        ticks(8);
        rd_chk("evt_cleared", 8'h20, 32'h0);

        // switches
        sw = 18'h2A5C3;
        tick();
        rd_chk("sw_1clk", 8'h00, 32'h0);
        tick();
        rd_chk("sw_2clk", 8'h00, 32'h2A5C3);
        rd_chk("chg_2clk", 8'h30, 32'h0);
        tick();
        rd_chk("chg_3clk", 8'h30, 32'h2A5C3);
        wr(8'h30, 32'h3FFFF);
        rd_chk("chg_clr", 8'h30, 32'h0);
        tick();
        rd_chk("chg_stays_clr", 8'h30, 32'h0);

        // irq from a masked key event
        wr(8'h40, 32'h1);
        key[0] = 1'b0;
        ticks(6);
        rd_chk("irq_evt", 8'h20, 32'h1);
        check("irq_same_clk", {31'h0, irq}, 32'h0);
        tick();
        check("irq_next_clk", {31'h0, irq}, 32'h1);
        wr(8'h20, 32'h1);
        check("irq_at_clr", {31'h0, irq}, 32'h1);
        tick();
        check("irq_dropped", {31'h0, irq}, 32'h0);
        key[0] = 1'b1;
        ticks(8);

        // reset in the middle of a key2 debounce, key2 kept low
        key[2] = 1'b0;
        ticks(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_chk("mid_rst_key", 8'h10, 32'h0);
        rd_chk("mid_rst_evt", 8'h20, 32'h0);
        rd_chk("mid_rst_mask", 8'h40, 32'h0);
        rd_chk("mid_rst_chg", 8'h30, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            rd_chk("post_rst_key", 8'h10, (c == 6) ? 32'h4 : 32'h0);
            rd_chk("post_rst_evt", 8'h20, (c == 6) ? 32'h4 : 32'h0);
            rd_chk("post_rst_chg", 8'h30, (c >= 3) ? 32'h2A5C3 : 32'h0);
        end
        rd_chk("unmapped_50", 8'h50, 32'h0);
        rd_chk("unmapped_ff2", 8'hFF, 32'h0);
        key = 4'hF;
        ticks(8);

        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [7:0] a;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) key[i] = ~key[i];
            if ($urandom_range(0, 19) == 0) sw = 18'($urandom);
            case ($urandom_range(0, 5))
                0: a = 8'h00;
                1: a = 8'h10;
                2: a = 8'h20;
                3: a = 8'h30;
                4: a = 8'h40;
                default: a = 8'($urandom);
            endcase
            bus_if.addr  = a;
            bus_if.wdata = $urandom;
            bus_if.wren  = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 399) == 0);
            #1;
            check("rand_rdata", bus_if.rdata, m_read(a));
            check("rand_irq", {31'h0, irq}, {31'h0, m_irq});
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        bus_if.wren = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
